booth_mult_ctrl: RTL

BOOTH_MULT_CTRL -- requirements
Module: booth_mult_ctrl

---
 rtl/booth_mult_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl: sequential signed 32x32 multiplier using radix-2 Booth
// recoding. It runs 32 iterations, one per clock, and keeps the low 32
// product bits plus a signed-overflow flag.
//
// Ports
//   clock          rising-edge clock
//   resetn         asynchronous active-low reset
//   ctrl_MULT      start strobe; one high cycle is one request (restarts if busy)
//   data_operandA  multiplicand, two's complement, sampled on the start edge
//   data_operandB  multiplier, two's complement, sampled on the start edge
//   data_result    low 32 bits of the product, held until the next completion
//   data_exception set when the 64-bit product does not fit in 32 signed bits
//   data_resultRDY one-cycle completion pulse
//   busy           high while iterations are pending
module booth_mult_ctrl (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] u_q, u_d;     // upper partial product, one extra sign bit
  logic [31:0] l_q, l_d;     // lower half; starts out holding the multiplier
  logic        g_q, g_d;     // Booth guard bit to the right of l_q[0]
  logic [32:0] m_q, m_d;     // sign-extended multiplicand
  logic [31:0] res_q, res_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;

  logic [32:0] u_sum;
  logic [32:0] u_sh;
  logic [31:0] l_sh;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      u_q     <= '0;
      l_q     <= '0;
      g_q     <= 1'b0;
      m_q     <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      u_q     <= u_d;
      l_q     <= l_d;
      g_q     <= g_d;
      m_q     <= m_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    u_d     = u_q;
    l_d     = l_q;
    g_d     = g_q;
    m_d     = m_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;

    // Booth step on {L[0], guard}. The 33-bit width keeps -(-2^31) exact.
    u_sum = u_q;
    case ({l_q[0], g_q})
      2'b01:   u_sum = u_q + m_q;
      2'b10:   u_sum = u_q - m_q;
      default: u_sum = u_q;
    endcase
    // Arithmetic right shift of {U, L, guard} by one.
    u_sh = {u_sum[32], u_sum[32:1]};
    l_sh = {u_sum[0], l_q[31:1]};

    if (ctrl_MULT) begin
      // A start takes priority over everything, including a completing step.
      state_d = S_RUN;
      cnt_d   = '0;
      u_d     = '0;
      l_d     = data_operandB;
      g_d     = 1'b0;
      m_d     = {data_operandA[31], data_operandA};
    end else if (state_q == S_RUN) begin
      u_d   = u_sh;
      l_d   = l_sh;
      g_d   = l_q[0];
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        state_d = S_IDLE;
        res_d   = l_sh;
        // The product fits in 32 bits only if the upper word is all copies
        // of the low word's sign bit.
        exc_d   = (u_sh[31:0] != {32{l_sh[31]}});
        rdy_d   = 1'b1;
      end
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q == S_RUN);

endmodule
